fsk_tone_sequencer: RTL and testbench

FSK_TONE_SEQUENCER -- requirements
Module: fsk_tone_sequencer

---
 rtl/fsk_tone_sequencer.sv | 142 ++++++++++++++
 tb/tb_fsk_tone_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_tone_sequencer.sv
// 4-FSK tone sequencer: maps accepted symbols to DDS frequency control words
// held for sym_len cycles each. Define FSK_TONE_GUARD_EN to add a silent guard interval after a burst.
module fsk_tone_sequencer #(
    parameter int FCW_W = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       sym_data,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [FCW_W-1:0] cfg_wdata,
    output logic [FCW_W-1:0] fcw,
    output logic             busy,
    output logic             tx_done,
    output logic [1:0]       state_dbg
);

    // Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready;
    // sym_data must be stable while sym_valid is high, and sym_ready never depends on sym_valid.

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TONE  = 2'd1;
`ifdef FSK_TONE_GUARD_EN
    localparam logic [1:0] ST_GUARD = 2'd2;
`endif

    logic [1:0]       state;
    logic [FCW_W-1:0] tone_tbl [4];
    logic [LEN_W-1:0] sym_len;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] load_cnt;
    logic             hold_valid;
    logic [1:0]       hold_sym;
    logic             accept;
`ifdef FSK_TONE_GUARD_EN
    logic [LEN_W-1:0] guard_len;
    logic [LEN_W-1:0] guard_cnt;
`endif

    // sym_len of 0 is treated as 1, so the reload value saturates at 0.
    assign load_cnt  = (sym_len == '0) ? '0 : sym_len - LEN_W'(1);
    assign sym_ready = (state == ST_IDLE) || ((state == ST_TONE) && !hold_valid);
    assign accept    = sym_valid && sym_ready;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                tone_tbl[i] <= '0;
            end
            sym_len <= LEN_W'(1);
`ifdef FSK_TONE_GUARD_EN
            guard_len <= '0;
`endif
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0, 3'd1, 3'd2, 3'd3: tone_tbl[cfg_addr[1:0]] <= cfg_wdata;
                3'd4:                   sym_len <= cfg_wdata[LEN_W-1:0];
`ifdef FSK_TONE_GUARD_EN
                3'd5:                   guard_len <= cfg_wdata[LEN_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            fcw        <= '0;
            cnt        <= '0;
            hold_valid <= 1'b0;
            hold_sym   <= '0;
            tx_done    <= 1'b0;
`ifdef FSK_TONE_GUARD_EN
            guard_cnt  <= '0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        fcw   <= tone_tbl[sym_data];
                        cnt   <= load_cnt;
                        state <= ST_TONE;
                    end
                end
                ST_TONE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - LEN_W'(1);
                        if (accept) begin
                            hold_valid <= 1'b1;
                            hold_sym   <= sym_data;
                        end
                    end else if (hold_valid) begin
                        fcw        <= tone_tbl[hold_sym];
                        cnt        <= load_cnt;
                        hold_valid <= 1'b0;
                    end else if (accept) begin
                        // Single-cycle symbols: a symbol offered at the last count
                        // bypasses the hold so the tone stream stays gapless.
                        fcw <= tone_tbl[sym_data];
                        cnt <= load_cnt;
                    end else begin
                        fcw <= '0;
`ifdef FSK_TONE_GUARD_EN
                        if (guard_len != '0) begin
                            state     <= ST_GUARD;
                            guard_cnt <= guard_len - LEN_W'(1);
                        end else begin
                            state   <= ST_IDLE;
                            tx_done <= 1'b1;
                        end
`else
                        state   <= ST_IDLE;
                        tx_done <= 1'b1;
`endif
                    end
                end
`ifdef FSK_TONE_GUARD_EN
                ST_GUARD: begin
                    if (guard_cnt != '0) begin
                        guard_cnt <= guard_cnt - LEN_W'(1);
                    end else begin
                        state   <= ST_IDLE;
                        tx_done <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    fcw   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_tone_sequencer.sv
// Self-checking bench for fsk_tone_sequencer: bursts are compared cycle by cycle against
// an expected {busy, tx_done, fcw} trace derived from the symbol list and configuration.
module tb_fsk_tone_sequencer;
    localparam int FCW_W = 32;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             sym_valid;
    logic             sym_ready;
    logic [1:0]       sym_data;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [FCW_W-1:0] cfg_wdata;
    logic [FCW_W-1:0] fcw;
    logic             busy;
    logic             tx_done;
    logic [1:0]       state_dbg;

    fsk_tone_sequencer #(.FCW_W(FCW_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_data(sym_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .fcw(fcw), .busy(busy), .tx_done(tx_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference configuration as the bench believes it to be
    logic [31:0] table_m [4];
    int          len_m;
    int          guard_m;

    logic [1:0]  sym_q [$];
    logic [33:0] exp_q [$];
    logic [33:0] act_q [$];

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) table_m[i] = '0;
        len_m   = 1;
        guard_m = 0;
    endfunction

    function automatic void model_write(input int addr, input logic [31:0] data);
        if (addr < 4) table_m[addr] = data;
        else if (addr == 4) len_m = int'(data[15:0]);
`ifdef FSK_TONE_GUARD_EN
        else if (addr == 5) guard_m = int'(data[15:0]);
`endif
    endfunction

    // Symbol i starts at edge t_i (edge 0 = first acceptance) and lasts max(len,1) cycles;
    // a config write at edge w is seen only by loads happening at edges after w.
    function automatic void build_expected(input int wr_edge, input int wr_addr, input logic [31:0] wr_data);
        logic [31:0] old_tbl [4];
        logic [31:0] new_tbl [4];
        int old_len, new_len, old_g, new_g, t, len, g;
        logic use_new;
        for (int i = 0; i < 4; i++) old_tbl[i] = table_m[i];
        old_len = len_m;
        old_g   = guard_m;
        if (wr_edge >= 0) model_write(wr_addr, wr_data);
        for (int i = 0; i < 4; i++) new_tbl[i] = table_m[i];
        new_len = len_m;
        new_g   = guard_m;
        exp_q.delete();
        t = 0;
        foreach (sym_q[i]) begin
            use_new = (wr_edge >= 0) && (t > wr_edge);
            len = use_new ? new_len : old_len;
            if (len == 0) len = 1;
            for (int k = 0; k < len; k++)
                exp_q.push_back({1'b1, 1'b0, (use_new ? new_tbl[sym_q[i]] : old_tbl[sym_q[i]])});
            t += len;
        end
        g = ((wr_edge >= 0) && (t > wr_edge)) ? new_g : old_g;
`ifdef FSK_TONE_GUARD_EN
        for (int k = 0; k < g; k++) exp_q.push_back({1'b1, 1'b0, 32'h0});
`else
        if (g < 0) exp_q.push_back('0);
`endif
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        exp_q.push_back({1'b0, 1'b0, 32'h0});
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(addr);
        cfg_wdata = data;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        model_write(addr, data);
    endtask

    task automatic load_table(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d, input int len);
        cfg_write(0, a);
        cfg_write(1, b);
        cfg_write(2, c);
        cfg_write(3, d);
        cfg_write(4, 32'(len));
    endtask

    // Offers sym_q with sym_valid held high, optionally fires one config write at
    // edge wr_edge, and records samples until two cycles after busy falls.
    task automatic drive_burst(input int wr_edge, input int wr_addr, input logic [31:0] wr_data);
        int idx, e, tail;
        logic acc;
        act_q.delete();
        idx  = 0;
        e    = 0;
        tail = -1;
        while (e < 400 && tail != 0) begin
            sym_valid = (idx < sym_q.size());
            sym_data  = sym_valid ? sym_q[idx] : 2'd0;
            cfg_we    = (e == wr_edge);
            cfg_addr  = 3'(wr_addr);
            cfg_wdata = wr_data;
            acc = sym_valid && sym_ready;
            @(posedge clk);
            #1 cfg_we = 1'b0;
            if (acc) idx++;
            act_q.push_back({busy, tx_done, fcw});
            if (tail > 0) tail--;
            else if (tail < 0 && !busy) tail = 2;
            e++;
        end
        sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({busy, tx_done, sym_ready, fcw} !== {1'b0, 1'b0, 1'b1, 32'h0})
            $display("FAIL reset_state {busy,tx_done,sym_ready,fcw}: got %h expected %h",
                     {busy, tx_done, sym_ready, fcw}, {1'b0, 1'b0, 1'b1, 32'h0});
        else pass_cnt++;
    endtask

    task automatic test_single_symbol();
        load_table(32'h100, 32'h200, 32'h300, 32'h400, 4);
        sym_q = '{2'd2};
        build_expected(-1, 0, 0);
        drive_burst(-1, 0, 0);
        total_cnt++;
        if (act_q.size() !== exp_q.size())
            $display("FAIL single length: got %0d expected %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i])
                $display("FAIL single cycle %0d {busy,done,fcw}: got %h expected %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        sym_q = '{2'd0, 2'd3, 2'd1};
        build_expected(-1, 0, 0);
        drive_burst(-1, 0, 0);
        total_cnt++;
        if (act_q.size() !== exp_q.size())
            $display("FAIL b2b length: got %0d expected %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i])
                $display("FAIL b2b cycle %0d {busy,done,fcw}: got %h expected %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_len_zero();
        cfg_write(4, 32'h0);
        sym_q = '{2'd1, 2'd1};
        build_expected(-1, 0, 0);
        drive_burst(-1, 0, 0);
        total_cnt++;
        if (act_q.size() !== exp_q.size())
            $display("FAIL len0 length: got %0d expected %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i])
                $display("FAIL len0 cycle %0d {busy,done,fcw}: got %h expected %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
        cfg_write(4, 32'd4);
    endtask

    task automatic test_same_edge_write();
        for (int b = 0; b < 2; b++) begin
            sym_q = '{2'd3};
            build_expected((b == 0) ? 0 : -1, 3, 32'h999);
            drive_burst((b == 0) ? 0 : -1, 3, 32'h999);
            total_cnt++;
            if (act_q.size() !== exp_q.size())
                $display("FAIL same_edge_wr%0d length: got %0d expected %0d", b, act_q.size(), exp_q.size());
            else pass_cnt++;
            for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
                total_cnt++;
                if (act_q[i] !== exp_q[i])
                    $display("FAIL same_edge_wr%0d cycle %0d: got %h expected %h", b, i, act_q[i], exp_q[i]);
                else pass_cnt++;
            end
        end
        cfg_write(3, 32'h400);
    endtask

    task automatic test_len_write_mid_symbol();
        sym_q = '{2'd0, 2'd1};
        build_expected(1, 4, 32'd2);
        drive_burst(1, 4, 32'd2);
        total_cnt++;
        if (act_q.size() !== exp_q.size())
            $display("FAIL len_mid length: got %0d expected %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i])
                $display("FAIL len_mid cycle %0d {busy,done,fcw}: got %h expected %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
        cfg_write(4, 32'd4);
    endtask

    task automatic test_guard();
        cfg_write(5, 32'd3);
        sym_q = '{2'd2};
        build_expected(-1, 0, 0);
        drive_burst(-1, 0, 0);
        total_cnt++;
        if (act_q.size() !== exp_q.size())
            $display("FAIL guard length: got %0d expected %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i])
                $display("FAIL guard cycle %0d {busy,done,fcw}: got %h expected %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
        cfg_write(5, 32'd0);
    endtask

    task automatic test_reset_mid_tone();
        sym_valid = 1'b1;
        sym_data  = 2'd0;
        @(posedge clk);
        #1 sym_data = 2'd1;
        @(posedge clk);
        #1 sym_valid = 1'b0;
        total_cnt++;
        if (sym_ready !== 1'b0)
            $display("FAIL hold_full_ready: got %b expected 0", sym_ready);
        else pass_cnt++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, tx_done, sym_ready, fcw} !== {1'b0, 1'b0, 1'b1, 32'h0})
            $display("FAIL reset_mid_tone {busy,done,ready,fcw}: got %h expected %h",
                     {busy, tx_done, sym_ready, fcw}, {1'b0, 1'b0, 1'b1, 32'h0});
        else pass_cnt++;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if ({busy, tx_done, fcw} !== 34'h0)
                $display("FAIL after_abort cycle %0d {busy,done,fcw}: got %h expected 0", k, {busy, tx_done, fcw});
            else pass_cnt++;
        end
        // Reset also cleared the table to zero and sym_len to one.
        sym_q = '{2'd2};
        build_expected(-1, 0, 0);
        drive_burst(-1, 0, 0);
        total_cnt++;
        if (act_q.size() !== exp_q.size())
            $display("FAIL post_reset length: got %0d expected %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total_cnt++;
            if (act_q[i] !== exp_q[i])
                $display("FAIL post_reset cycle %0d {busy,done,fcw}: got %h expected %h", i, act_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int n, wr_edge, wr_addr;
        logic [31:0] wr_data;
        for (int it = 0; it < 12; it++) begin
            load_table($urandom() | 32'h1, $urandom() | 32'h1, $urandom() | 32'h1,
                       $urandom() | 32'h1, $urandom_range(0, 4));
            cfg_write(5, 32'($urandom_range(0, 3)));
            n = $urandom_range(1, 5);
            sym_q.delete();
            for (int k = 0; k < n; k++) sym_q.push_back(2'($urandom_range(0, 3)));
            wr_edge = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            wr_addr = $urandom_range(0, 7);
            wr_data = (wr_addr >= 4) ? 32'($urandom_range(0, 4)) : ($urandom() | 32'h1);
            build_expected(wr_edge, wr_addr, wr_data);
            drive_burst(wr_edge, wr_addr, wr_data);
            total_cnt++;
            if (act_q.size() !== exp_q.size())
                $display("FAIL random%0d length: got %0d expected %0d", it, act_q.size(), exp_q.size());
            else pass_cnt++;
            for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
                total_cnt++;
                if (act_q[i] !== exp_q[i])
                    $display("FAIL random%0d cycle %0d {busy,done,fcw}: got %h expected %h", it, i, act_q[i], exp_q[i]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        sym_valid = 1'b0;
        sym_data  = 2'd0;
        cfg_we    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_wdata = '0;
        apply_reset();
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_len_zero();
        test_same_edge_write();
        test_len_write_mid_symbol();
        test_guard();
        test_reset_mid_tone();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
